// File: rtl/fp_operand_queue.sv
// fp_operand_queue: circular FIFO of single-precision operand pairs feeding the
// FPU multiplier wrapper. Each entry carries a sequence tag and a flag marking
// operands with a zero/denormal or inf/NaN exponent.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready and out_valid come from registered pointers only, so neither
// depends combinationally on in_valid or out_ready.
module fp_operand_queue #(
   parameter int DEPTH = 8,
   parameter int TAG_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [31:0]              in_A,
   input  logic [31:0]              in_B,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [31:0]              out_A,
   output logic [31:0]              out_B,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_special,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0]    ONE_P = 1;
   localparam logic [TAG_W-1:0] ONE_T = 1;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [PW-1:0]    wp_q, wp_d;
   logic [PW-1:0]    rp_q, rp_d;
   logic [PW-1:0]    count_q, count_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   logic [31:0]      mem_a   [DEPTH];
   logic [31:0]      mem_b   [DEPTH];
   logic [TAG_W-1:0] mem_tag [DEPTH];
   logic             mem_sp  [DEPTH];

   logic empty, full, push, pop, we, special;

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = count_q;

   // Head is a plain combinational read; it only moves when rp moves.
   assign out_A       = mem_a[rp_q[AW-1:0]];
   assign out_B       = mem_b[rp_q[AW-1:0]];
   assign out_tag     = mem_tag[rp_q[AW-1:0]];
   assign out_special = mem_sp[rp_q[AW-1:0]];

   // Next-state for pointers, tag counter and occupancy; flush wins over push/pop.
   always_comb begin
      push    = in_valid && !full;
      pop     = !empty && out_ready;
      special = (in_A[30:23] == 8'h00) || (in_A[30:23] == 8'hFF) ||
                (in_B[30:23] == 8'h00) || (in_B[30:23] == 8'hFF);
      wp_d    = wp_q;
      rp_d    = rp_q;
      tag_d   = tag_q;
      count_d = count_q;
      we      = 1'b0;
      if (flush) begin
         rp_d    = wp_q;
         count_d = '0;
      end else begin
         if (push) begin
            wp_d  = wp_q + ONE_P;
            tag_d = tag_q + ONE_T;
            we    = 1'b1;
         end
         if (pop) begin
            rp_d = rp_q + ONE_P;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + ONE_P;
            2'b01:   count_d = count_q - ONE_P;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state; asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         tag_q   <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         tag_q   <= tag_d;
      end
   end

   // Entry storage; contents are never reset, only pointer-qualified.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_a[wp_q[AW-1:0]]   <= in_A;
         mem_b[wp_q[AW-1:0]]   <= in_B;
         mem_tag[wp_q[AW-1:0]] <= tag_q;
         mem_sp[wp_q[AW-1:0]]  <= special;
      end
   end

endmodule

// File: tb/tb_fp_operand_queue.sv
// Directed bench for fp_operand_queue: reset, fill/drain, simultaneous
// push/pop, special flag, flush with tag wrap (TAG_W=2 instance) and a
// stalled consumer with a tag scoreboard.
module tb_fp_operand_queue;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main instance (DEPTH=8, TAG_W=8)
   logic        flush0, in_valid, out_ready;
   logic [31:0] in_A, in_B;
   logic        in_ready, out_valid, out_special;
   logic [31:0] out_A, out_B;
   logic [7:0]  out_tag;
   logic [3:0]  count;

   // wrap instance (DEPTH=8, TAG_W=2)
   logic        flush1, in_valid1, out_ready1;
   logic        in_ready1, out_valid1, out_special1;
   logic [31:0] out_A1, out_B1;
   logic [1:0]  out_tag1;
   logic [3:0]  count1;

   fp_operand_queue #(.DEPTH(8), .TAG_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush0),
      .in_A(in_A), .in_B(in_B), .in_valid(in_valid), .in_ready(in_ready),
      .out_A(out_A), .out_B(out_B), .out_tag(out_tag), .out_special(out_special),
      .out_valid(out_valid), .out_ready(out_ready), .count(count)
   );

   fp_operand_queue #(.DEPTH(8), .TAG_W(2)) dut_w (
      .clk(clk), .rst(rst), .flush(flush1),
      .in_A(in_A), .in_B(in_B), .in_valid(in_valid1), .in_ready(in_ready1),
      .out_A(out_A1), .out_B(out_B1), .out_tag(out_tag1), .out_special(out_special1),
      .out_valid(out_valid1), .out_ready(out_ready1), .count(count1)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [72:0] exp_q[$];   // {A, B, tag, special}

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
             (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      tick;
      tick;
      rst = 1'b1;
   endtask

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
      in_A     = a;
      in_B     = b;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [72:0] ent;
      logic [72:0] prev_head;
      logic        prev_hold;
      int          pushes_left, stall, received;
      logic        push_fire, pop_fire;
      logic [7:0]  ptag;

      rst = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
      in_A = '0; in_B = '0;
      do_reset;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_count", count, 4'd0);

      // --- asynchronous reset mid-operation ---
      push_pair(32'h40A00000, 32'h40A00000);
      check("pre_rst_valid", out_valid, 1'b1);
      #3 rst = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1'b1);
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_count", count, 4'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      push_pair(32'h3F800000, 32'h40000000);
      check("first_valid", out_valid, 1'b1);
      check("first_A", out_A, 32'h3F800000);
      check("first_B", out_B, 32'h40000000);
      check("first_tag", out_tag, 8'd0);
      check("first_special", out_special, 1'b0);
      out_ready = 1'b1; tick; out_ready = 1'b0;
      check("first_popped", out_valid, 1'b0);

      // --- fill and drain ---
      do_reset;
      for (int i = 0; i < 8; i++) push_pair(32'h3F800000 + i, 32'h40000000 + i);
      check("fill_count", count, 4'd8);
      check("fill_in_ready", in_ready, 1'b0);
      push_pair(32'hDEADBEEF, 32'hDEADBEEF);
      check("ninth_ignored", count, 4'd8);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_valid", out_valid, 1'b1);
         check("drain_tag", out_tag, i);
         check("drain_A", out_A, 32'h3F800000 + i);
         tick;
      end
      out_ready = 1'b0;
      check("drain_empty", out_valid, 1'b0);
      check("drain_count", count, 4'd0);

      // --- simultaneous push/pop (tags continue from 8) ---
      for (int i = 0; i < 3; i++) push_pair(32'h40000000 + i, 32'h40400000);
      check("sim_count3", count, 4'd3);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_A = 32'h41000000 + i;
         check("sim_tag", out_tag, 8 + i);
         tick;
         check("sim_count", count, 4'd3);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_pair(32'h42000000 + i, 32'h40400000);
      check("sim_full", count, 4'd8);
      in_valid = 1'b1; out_ready = 1'b1;
      tick;
      in_valid = 1'b0; out_ready = 1'b0;
      check("full_pop_only", count, 4'd7);
      check("full_pop_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         check("full_drain_tag", out_tag, 19 + i);
         tick;
      end
      out_ready = 1'b0;
      check("full_drain_empty", out_valid, 1'b0);

      // --- special flag ---
      push_pair(32'h7F800000, 32'h3F800000);
      push_pair(32'h00000000, 32'h40400000);
      push_pair(32'h40000000, 32'h40400000);
      out_ready = 1'b1;
      check("special_inf", out_special, 1'b1); tick;
      check("special_zero", out_special, 1'b1); tick;
      check("special_norm", out_special, 1'b0); tick;
      out_ready = 1'b0;

      // --- flush and tag wrap on TAG_W=2 instance ---
      in_A = 32'h3F800000; in_B = 32'h3F800000;
      in_valid1 = 1'b1; tick; tick; tick;
      check("wrap_count3", count1, 4'd3);
      flush1 = 1'b1; tick;
      flush1 = 1'b0; in_valid1 = 1'b0;
      check("flush_count", count1, 4'd0);
      check("flush_empty", out_valid1, 1'b0);
      in_valid1 = 1'b1; tick; in_valid1 = 1'b0;
      check("wrap_tag3", out_tag1, 2'd3);
      check("wrap_count1", count1, 4'd1);
      in_valid1 = 1'b1; out_ready1 = 1'b1; tick;
      in_valid1 = 1'b0; out_ready1 = 1'b0;
      check("wrap_tag0", out_tag1, 2'd0);
      check("wrap_count_same", count1, 4'd1);

      // --- backpressure: consumer stalls 7 cycles after each accept ---
      do_reset;
      pushes_left = 50; stall = 0; received = 0; ptag = 8'd0;
      prev_hold = 1'b0; prev_head = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (pushes_left == 0 && exp_q.size() == 0) break;
         check("bp_count", count, exp_q.size());
         if (prev_hold && out_valid)
            check("bp_hold", {out_A, out_B, out_tag, out_special}, prev_head);
         in_valid  = (pushes_left > 0) && ($urandom_range(0, 3) != 0);
         in_A      = $urandom();
         in_B      = $urandom();
         out_ready = (stall == 0);
         push_fire = in_valid && in_ready;
         pop_fire  = out_valid && out_ready;
         if (pop_fire) begin
            ent = exp_q.pop_front();
            check("bp_head", {out_A, out_B, out_tag, out_special}, ent);
            received++;
            stall = 7;
         end else if (stall > 0) begin
            stall--;
         end
         if (push_fire) begin
            exp_q.push_back({in_A, in_B, ptag, is_special(in_A, in_B)});
            ptag++;
            pushes_left--;
         end
         prev_hold = out_valid && !out_ready;
         prev_head = {out_A, out_B, out_tag, out_special};
         tick;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("bp_received", received, 50);
      check("bp_leftover", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_operand_queue.md
# fp_operand_queue

Elastic operand buffer placed directly upstream of the FPU multiplier wrapper. It accepts single-precision operand pairs (A, B) from the stimulus/driver side over a valid/ready handshake and stores them in a circular FIFO. It presents them in order on the wrapper's input port, so the producer is never stalled by the wrapper's one-transaction-at-a-time WAIT/SEND protocol. Each entry is tagged at enqueue with a sequence number and an IEEE-754 special-operand flag, for scoreboard alignment downstream.

## Interface

Parameters:
- DEPTH, 8: number of entries; power of two, 2..64.
- TAG_W, 8: width of the sequence tag; wraps modulo 2^TAG_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it (0) clears state immediately; deassertion is synchronous to clk.
- flush  in  1  synchronous clear of all entries; tag counter is kept.
- in_A  in  32  operand A, IEEE-754 single.
- in_B  in  32  operand B, IEEE-754 single.
- in_valid  in  1  producer has a pair.
- in_ready  out  1  queue can accept; equals !full.
- out_A  out  32  head operand A.
- out_B  out  32  head operand B.
- out_tag  out  TAG_W  head sequence tag.
- out_special  out  1  head has A or B with exponent 8'h00 or 8'hFF.
- out_valid  out  1  head entry present; equals !empty.
- out_ready  in  1  consumer (FPU wrapper in_inter.ready) accepts head.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation

- Storage: DEPTH × (32+32+TAG_W+1) register array, write pointer wp, read pointer rp, each $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
  - empty = (wp == rp).
  - full = (wp[MSB] != rp[MSB]) and (wp[low] == rp[low]).
- Push: in_valid && in_ready.
  - Writes {in_A, in_B, tag_cnt, special} at wp[low].
  - wp increments and tag_cnt increments; both wrap naturally.
- Pop: out_valid && out_ready. rp increments.
- special = (in_A[30:23]==0 || in_A[30:23]==8'hFF || in_B[30:23]==0 || in_B[30:23]==8'hFF), computed at enqueue.
- Simultaneous push and pop:
  - Legal when not empty and not full.
  - count is unchanged and both pointers advance.
- When full, in_ready=0 even if a pop occurs in the same cycle. There is no same-cycle pass-through of freed space.
- When empty, out_valid=0. A push is visible at the head one cycle later. There is no combinational bypass.
- Outputs out_A/out_B/out_tag/out_special are a combinational read of array[rp[low]]. Their value is don't-care while out_valid=0. The bench must not check them while out_valid=0.
- Head stability: while out_valid=1 and out_ready=0, all head outputs hold unchanged.
- flush: rp<=wp, count<=0. It overrides any push or pop in the same cycle; an input presented that cycle is dropped. tag_cnt is not reset.
- Reset values: wp=rp=0, tag_cnt=0, count=0, in_ready=1, out_valid=0. Array contents are not reset.
- Reset mid-operation: all entries are discarded asynchronously. The first post-reset push receives tag 0.
- count: registered, +1 on push only, −1 on pop only, unchanged on both or neither. Always equals wp−rp.

## Timing

- Enqueue-to-head latency: 1 cycle. A push at edge N gives out_valid=1 after edge N when the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- Once the consumer lowers ready in WAIT→SEND, the head holds until the consumer re-raises ready.
- in_ready and out_valid are derived from registered pointers only. There is no combinational path from in_valid or out_ready.
- out_valid and in_ready change only on clk edges or on asynchronous reset assertion.

## Test plan

- Reset/idle:
  - Stimulus: rst=0 mid-cycle, then release.
  - Required: immediately in_ready=1, out_valid=0, count=0; first push in_A=32'h3F800000, in_B=32'h40000000 appears next cycle with out_tag=0, out_special=0.
- Fill and drain (DEPTH=8):
  - Stimulus: push 8 pairs with out_ready=0.
  - Required: count=8, in_ready=0; a 9th in_valid is ignored.
  - Then out_ready=1 for 8 cycles: tags 0..7 pop in order, then out_valid=0.
- Simultaneous push/pop:
  - Stimulus: count=3, then in_valid=out_ready=1 for 10 cycles.
  - Required: count stays 3; tags are output strictly sequentially.
  - Same stimulus at count=8: only the pop occurs, count=7.
- Special flag:
  - Stimulus: push A=32'h7F800000 (inf), B=32'h3F800000, then A=32'h00000000, B=32'h40400000, then A=32'h40000000, B=32'h40400000.
  - Required: out_special = 1, 1, 0.
- Flush and tag wrap:
  - Stimulus: TAG_W=2, push 3 entries, assert flush together with in_valid.
  - Required: count=0 next cycle, pushed entry dropped; next push carries tag 3, the following push tag 0.
- Backpressure from the FPU wrapper:
  - Stimulus: model the consumer holding out_ready=0 for 7 cycles after each accept.
  - Required: head outputs stay constant during the stall; no entry is lost or duplicated across 50 random pairs (scoreboard on tag).
